// File: rtl/output_port_receiver_pkg.sv
// Shared CPU definitions used by the OUT-port receiver and the datapath stages.
package output_port_receiver_pkg;

    // Width of one CPU datapath word, shared with the EXM and write-back stages.
    localparam int CPU_DATA_WIDTH  = 16;

    // Default number of buffered OUT writes.
    localparam int PORT_FIFO_DEPTH = 4;

endpackage

// File: rtl/output_port_receiver_sync_fifo.sv
// Generic show-ahead synchronous FIFO. Full/empty are decoded from the
// occupancy counter, so pointers can wrap freely without an extra bit.
module sync_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             pop_s;
    logic             push_s;

    // Guard the strobes so the FIFO can never underflow or overwrite live data.
    always_comb begin
        pop_s  = pop & ~empty;
        push_s = push & (~full | pop_s);
    end

    // Storage is not reset; entries beyond the count are never observed.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Status and head-of-queue decode from registered state only.
    always_comb begin
        rdata = mem_r[rd_ptr_r];
        count = count_r;
        full  = (count_r == CNT_FULL);
        empty = (count_r == {CNT_W{1'b0}});
    end

endmodule

// File: rtl/output_port_receiver.sv
// Receiving end of the CPU OUT instruction path: buffers OUT writes, drains
// them over valid/ready, and tracks the last accepted value and drops.
module output_port_receiver
    import output_port_receiver_pkg::*;
#(
    parameter  int DATA_WIDTH = CPU_DATA_WIDTH,
    parameter  int DEPTH      = PORT_FIFO_DEPTH,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_out_write,
    input  logic [DATA_WIDTH-1:0] i_out_data,
    output logic                  o_full,
    output logic                  o_port_valid,
    output logic [DATA_WIDTH-1:0] o_port_data,
    input  logic                  i_port_ready,
    output logic [DATA_WIDTH-1:0] o_last_value,
    output logic [CNT_W-1:0]      o_count,
    output logic                  o_overflow,
    input  logic                  i_clear_overflow
);

    logic                  full_s;
    logic                  empty_s;
    logic                  valid_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  drop_s;
    logic [DATA_WIDTH-1:0] head_s;
    logic [CNT_W-1:0]      count_s;
    logic [DATA_WIDTH-1:0] last_value_r;
    logic                  overflow_r;

    // Handshake qualification; a full FIFO still accepts a write when the head leaves.
    always_comb begin
        valid_s = ~empty_s;
        pop_s   = valid_s & i_port_ready;
        push_s  = i_out_write & (~full_s | pop_s);
        drop_s  = i_out_write & full_s & ~pop_s;
    end

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_reset),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (i_out_data),
        .rdata (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Visible port register: follows every accepted OUT write.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            last_value_r <= {DATA_WIDTH{1'b0}};
        end else if (push_s) begin
            last_value_r <= i_out_data;
        end else begin
            last_value_r <= last_value_r;
        end
    end

    // Sticky drop flag; a new drop takes priority over a clear in the same cycle.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (i_clear_overflow) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Output drive; head data is forced to zero while nothing is buffered.
    always_comb begin
        o_full       = full_s;
        o_port_valid = valid_s;
        o_count      = count_s;
        o_last_value = last_value_r;
        o_overflow   = overflow_r;
        if (valid_s) begin
            o_port_data = head_s;
        end else begin
            o_port_data = {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_output_port_receiver.sv
// Scoreboard bench for output_port_receiver: stimulus pushes expected words,
// a negedge monitor pops and compares every accepted head.
module tb_output_port_receiver;

    localparam int W = 16;

    logic          clk;
    logic          rst_n;
    logic          out_write;
    logic [W-1:0]  out_data;
    logic          full;
    logic          port_valid;
    logic [W-1:0]  port_data;
    logic          port_ready;
    logic [W-1:0]  last_value;
    logic [2:0]    count;
    logic          overflow;
    logic          clear_overflow;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] sb_q [$];

    output_port_receiver dut (
        .i_clk            (clk),
        .i_reset          (rst_n),
        .i_out_write      (out_write),
        .i_out_data       (out_data),
        .o_full           (full),
        .o_port_valid     (port_valid),
        .o_port_data      (port_data),
        .i_port_ready     (port_ready),
        .o_last_value     (last_value),
        .o_count          (count),
        .o_overflow       (overflow),
        .i_clear_overflow (clear_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [W-1:0] d, input logic rdy);
        out_write  = 1'b1;
        out_data   = d;
        port_ready = rdy;
        cyc();
        out_write  = 1'b0;
        port_ready = 1'b0;
    endtask

    task automatic drain(input int n);
        port_ready = 1'b1;
        repeat (n) cyc();
        port_ready = 1'b0;
    endtask

    // Monitor: a head accepted this cycle must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && port_valid && port_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got 0x%0h expected no data", port_data);
            end else begin
                check("pop_data", {16'h0, port_data}, {16'h0, sb_q.pop_front()});
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; out_write = 1'b0; out_data = 16'h0000;
        port_ready = 1'b0; clear_overflow = 1'b0;
        repeat (2) cyc();
        check("rst_valid", {31'h0, port_valid}, 32'h0);
        check("rst_full",  {31'h0, full}, 32'h0);
        check("rst_data",  {16'h0, port_data}, 32'h0);
        check("rst_count", {29'h0, count}, 32'h0);
        check("rst_last",  {16'h0, last_value}, 32'h0);
        check("rst_ovf",   {31'h0, overflow}, 32'h0);
        rst_n = 1'b1;
        cyc();

        // Single write, held, then consumed.
        sb_q.push_back(16'h1234);
        write(16'h1234, 1'b0);
        check("one_valid", {31'h0, port_valid}, 32'h1);
        check("one_data",  {16'h0, port_data}, 32'h1234);
        check("one_last",  {16'h0, last_value}, 32'h1234);
        check("one_count", {29'h0, count}, 32'h1);
        cyc();
        check("one_stable", {16'h0, port_data}, 32'h1234);
        drain(1);
        check("one_empty_valid", {31'h0, port_valid}, 32'h0);
        check("one_empty_data",  {16'h0, port_data}, 32'h0);

        // Fill across the pointer wrap, then drain in order.
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(16'hA000 + 16'(i));
            write(16'hA000 + 16'(i), 1'b0);
        end
        check("fill_full",  {31'h0, full}, 32'h1);
        check("fill_count", {29'h0, count}, 32'h4);
        drain(4);
        check("drain_count", {29'h0, count}, 32'h0);
        check("drain_full",  {31'h0, full}, 32'h0);

        // Refill, then a dropped write.
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(16'hA000 + 16'(i));
            write(16'hA000 + 16'(i), 1'b0);
        end
        write(16'hBEEF, 1'b0);
        check("drop_ovf",   {31'h0, overflow}, 32'h1);
        check("drop_last",  {16'h0, last_value}, 32'hA003);
        check("drop_count", {29'h0, count}, 32'h4);
        clear_overflow = 1'b1;
        cyc();
        clear_overflow = 1'b0;
        check("clear_ovf", {31'h0, overflow}, 32'h0);

        // Full with write and ready together: pass-through keeps count at DEPTH.
        sb_q.push_back(16'hC0DE);
        write(16'hC0DE, 1'b1);
        check("full_rw_count", {29'h0, count}, 32'h4);
        check("full_rw_ovf",   {31'h0, overflow}, 32'h0);
        check("full_rw_last",  {16'h0, last_value}, 32'hC0DE);
        check("full_rw_head",  {16'h0, port_data}, 32'hA001);

        // Drop and clear in the same cycle: the drop wins.
        clear_overflow = 1'b1;
        write(16'hDEAD, 1'b0);
        clear_overflow = 1'b0;
        check("set_wins_ovf",  {31'h0, overflow}, 32'h1);
        check("set_wins_last", {16'h0, last_value}, 32'hC0DE);
        clear_overflow = 1'b1;
        cyc();
        clear_overflow = 1'b0;
        drain(4);
        check("tail_count", {29'h0, count}, 32'h0);

        // Empty with write and ready together: no bypass.
        sb_q.push_back(16'h0055);
        out_write = 1'b1; out_data = 16'h0055; port_ready = 1'b1;
        cyc();
        out_write = 1'b0;
        check("nobyp_valid", {31'h0, port_valid}, 32'h1);
        check("nobyp_data",  {16'h0, port_data}, 32'h0055);
        check("nobyp_count", {29'h0, count}, 32'h1);
        cyc();
        port_ready = 1'b0;
        check("nobyp_drained", {29'h0, count}, 32'h0);

        // Asynchronous reset in the middle of activity.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) sb_q.push_back(16'h5000 + 16'(i));
            write(16'h5000 + 16'(i), 1'b0);
        end
        check("pre_rst_ovf", {31'h0, overflow}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("arst_valid", {31'h0, port_valid}, 32'h0);
        check("arst_full",  {31'h0, full}, 32'h0);
        check("arst_data",  {16'h0, port_data}, 32'h0);
        check("arst_count", {29'h0, count}, 32'h0);
        check("arst_last",  {16'h0, last_value}, 32'h0);
        check("arst_ovf",   {31'h0, overflow}, 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();
        sb_q.push_back(16'h7777);
        write(16'h7777, 1'b0);
        check("post_rst_data",  {16'h0, port_data}, 32'h7777);
        check("post_rst_count", {29'h0, count}, 32'h1);
        drain(1);

        check("sb_empty", sb_q.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
